seq_match_ctrl: RTL



---
 rtl/seq_match_ctrl_pkg.sv | 10 +
 rtl/seq_match_core.sv | 41 ++++
 rtl/seq_match_ctrl.sv | 96 +++++++++
 3 files changed

// File: rtl/seq_match_ctrl_pkg.sv
// seq_match_ctrl_pkg: shared FSM state encoding and default sizing for the pattern-match run controller
package seq_match_ctrl_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam int PAT_W_DEF  = 8;
    localparam int LEN_W_DEF  = 4;
    localparam int CNT_W_DEF  = 8;
    localparam int TO_CYC_DEF = 255;
endpackage

// File: rtl/seq_match_core.sv
// seq_match_core: serial history shift register, fill counter and length-masked pattern compare
import seq_match_ctrl_pkg::*;
module seq_match_core #(
    parameter int PAT_W = PAT_W_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_shift,
    input  logic             i_bit,
    input  logic [PAT_W-1:0] i_pat,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_hit
);
    logic [PAT_W-1:0] hist, hist_nx, mask;
    logic [PAT_W:0]   ext;
    logic [LEN_W-1:0] fill, fill_nx;

    assign ext     = {hist, i_bit};
    assign hist_nx = ext[PAT_W-1:0];
    assign fill_nx = (fill == LEN_W'(PAT_W)) ? fill : fill + 1'b1;
    assign o_hit   = i_shift && (fill_nx >= i_len) && (((hist_nx ^ i_pat) & mask) == '0);

    // only the low len bits of history and pattern take part in the compare
    always_comb begin
        mask = '0;
        for (int i = 0; i < PAT_W; i++) mask[i] = LEN_W'(i) < i_len;
    end

    // history and fill advance on each qualified bit; cleared when a run starts
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            hist <= '0;
            fill <= '0;
        end else if (i_shift) begin
            hist <= hist_nx;
            fill <= fill_nx;
        end
    end
endmodule

// File: rtl/seq_match_ctrl.sv
// seq_match_ctrl: run FSM and match counting for a programmable serial pattern; SEQ_MATCH_TIMEOUT_EN adds an idle timeout
import seq_match_ctrl_pkg::*;
module seq_match_ctrl #(
    parameter int PAT_W  = PAT_W_DEF,
    parameter int LEN_W  = LEN_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int TO_CYC = TO_CYC_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic [PAT_W-1:0] i_pat,
    input  logic [LEN_W-1:0] i_pat_len,
    input  logic [CNT_W-1:0] i_match_limit,
    input  logic             i_seq_vld,
    input  logic             i_seq,
    output logic             o_busy,
    output logic             o_match,
    output logic [CNT_W-1:0] o_match_cnt,
    output logic             o_done,
    output logic             o_timeout
);
    logic [1:0]       state;
    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q, len_cl;
    logic [CNT_W-1:0] lim_q;
    logic             run, accept, hit, lim_hit, to_hit, fin, timeout_q;

    assign run       = state == ST_RUN;
    assign accept    = (state == ST_IDLE) && i_start;
    assign len_cl    = (i_pat_len == '0) ? LEN_W'(1) : (i_pat_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : i_pat_len;
    assign lim_hit   = hit && (lim_q != '0) && (({1'b0, o_match_cnt} + 1'b1) == {1'b0, lim_q});
    assign fin       = lim_hit || i_stop || to_hit;
    assign o_busy    = run;
    assign o_done    = state == ST_DONE;
    assign o_timeout = timeout_q;

    seq_match_core #(.PAT_W(PAT_W), .LEN_W(LEN_W)) u_core (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (accept),
        .i_shift (run && i_seq_vld),
        .i_bit   (i_seq),
        .i_pat   (pat_q),
        .i_len   (len_q),
        .o_hit   (hit)
    );

`ifdef SEQ_MATCH_TIMEOUT_EN
    localparam int TO_W = $clog2(TO_CYC + 1);
    logic [TO_W-1:0] idle_cnt;

    assign to_hit = run && !i_seq_vld && (idle_cnt == TO_W'(TO_CYC - 1));

    // consecutive idle RUN cycles; any valid bit or a new run restarts the count
    always_ff @(posedge i_clk) begin
        if (i_rst || accept || i_seq_vld) idle_cnt <= '0;
        else if (run) idle_cnt <= idle_cnt + 1'b1;
    end
`else
    logic unused_to;

    assign to_hit    = 1'b0;
    assign unused_to = TO_CYC != 0;
`endif

    // run FSM with shadow config, saturating match counter and sticky timeout flag
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            pat_q       <= '0;
            len_q       <= '0;
            lim_q       <= '0;
            o_match     <= 1'b0;
            o_match_cnt <= '0;
            timeout_q   <= 1'b0;
        end else begin
            o_match <= hit;
            if (accept) begin
                state       <= ST_RUN;
                pat_q       <= i_pat;
                len_q       <= len_cl;
                lim_q       <= i_match_limit;
                o_match_cnt <= '0;
                timeout_q   <= 1'b0;
            end else if (run) begin
                if (hit && (o_match_cnt != '1)) o_match_cnt <= o_match_cnt + 1'b1;
                if (to_hit) timeout_q <= 1'b1;
                if (fin) state <= ST_DONE;
            end else if (state != ST_IDLE) begin
                state <= ST_IDLE;
            end
        end
    end
endmodule
